// File: rtl/fifo_wr_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fifo_wr_arb_pkg                                             |
// | Purpose  : Shared types and default constants for the FIFO write       |
// |            arbiter: arbiter state encoding and default FIFO geometry.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package fifo_wr_arb_pkg;

   localparam int c_default_data_w = 8;
   localparam int c_default_depth  = 64;
   localparam int c_stat_w         = 16;
   localparam int c_beat_w         = 8;    // holds beat counts up to 255

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

endpackage : fifo_wr_arb_pkg
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rr_picker                                                   |
// | Purpose  : Combinational round-robin selector. Picks the first set bit |
// |            of req starting at rr_ptr and wrapping modulo NUM_REQ.      |
// | Ports    : req    - request vector                                     |
// |            rr_ptr - index with highest priority this cycle             |
// |            gnt    - one-hot selection (all zero when no request)       |
// |            idx    - binary index of the selection                      |
// |            valid  - at least one request present                       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module rr_picker
   import fifo_wr_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   int w_pos;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      w_pos = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // rr_ptr is always below NUM_REQ, so one subtraction wraps it.
         w_pos = int'(rr_ptr) + k;
         if (w_pos >= NUM_REQ) begin
            w_pos = w_pos - NUM_REQ;
         end
         if (!valid && req[w_pos]) begin
            valid      = 1'b1;
            gnt[w_pos] = 1'b1;
            idx        = IDX_W'(w_pos);
         end
      end
   end

endmodule : rr_picker
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fifo_wr_arbiter                                             |
// | Purpose  : Round-robin, burst-capable arbiter sharing one FIFO write   |
// |            port among NUM_REQ requesters. Throttles on FIFO occupancy  |
// |            so no write is ever issued into a full buffer.              |
// | Ports    : clk, rst (sync, active-high)                                |
// |            req/req_data/req_last - per-requester write interface       |
// |            gnt        - one-hot combinational beat accept              |
// |            fifo_wr_en/fifo_din   - registered FIFO write port          |
// |            fifo_full/fifo_count  - FIFO status                         |
// |            busy       - registered, high while a burst is open         |
// |            owner      - registered index of current/last owner         |
// |            stat_beats - per-requester accepted-beat counters           |
// |                         (only with FIFO_WR_ARB_STATS_EN defined)       |
// | Options  : FIFO_WR_ARB_STATS_EN enables the stat_beats counters.       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = c_default_data_w,
   parameter int DEPTH     = c_default_depth,
   parameter int CNT_W     = 8,
   parameter int MAX_BURST = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          gnt,
   output logic                        fifo_wr_en,
   output logic [DATA_W-1:0]           fifo_din,
   input  logic                        fifo_full,
   input  logic [CNT_W-1:0]            fifo_count,
   output logic                        busy,
   output logic [$clog2(NUM_REQ)-1:0]  owner
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NUM_REQ*c_stat_w-1:0] stat_beats
`endif
);

   localparam int              c_idx_w     = $clog2(NUM_REQ);
   localparam logic [CNT_W:0]  c_depth_ext = (CNT_W+1)'(DEPTH);
   localparam logic [c_beat_w:0] c_max_burst = (c_beat_w+1)'(MAX_BURST);

   arb_state_t                r_state;
   arb_state_t                w_next_state;
   logic [c_idx_w-1:0]        r_rr_ptr;
   logic [c_idx_w-1:0]        r_owner;
   logic [c_beat_w-1:0]       r_beat_cnt;
   logic                      r_hold;
   logic                      r_fifo_wr_en;
   logic [DATA_W-1:0]         r_fifo_din;
   logic                      r_busy;

   logic [NUM_REQ-1:0]        w_pick_gnt;
   logic [c_idx_w-1:0]        w_pick_idx;
   logic                      w_pick_valid;
   logic [NUM_REQ-1:0]        w_gnt;
   logic [c_idx_w-1:0]        w_sel_idx;
   logic [DATA_W-1:0]         w_sel_data;
   logic                      w_accept;
   logic                      w_end_burst;
   logic                      w_space_ok;
   logic [c_beat_w:0]         w_beat_next;
   logic                      w_burst_cap;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_idx_w)
   ) u_rr_picker (
      .req    (req),
      .rr_ptr (r_rr_ptr),
      .gnt    (w_pick_gnt),
      .idx    (w_pick_idx),
      .valid  (w_pick_valid)
   );

   // fifo_count lags our own write by one cycle, so the registered write
   // still in flight is added before comparing against capacity.
   assign w_space_ok = !fifo_full &&
                       (({1'b0, fifo_count} + {{CNT_W{1'b0}}, r_fifo_wr_en}) < c_depth_ext);

   assign w_beat_next = {1'b0, r_beat_cnt} + {{c_beat_w{1'b0}}, 1'b1};
   assign w_burst_cap = (w_beat_next >= c_max_burst);

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_sel_idx == c_idx_w'(i)) begin
            w_sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // r_hold forces the single idle cycle that follows every burst end,
   // including single-beat bursts that never leave IDLE.
   always_comb begin
      w_next_state = r_state;
      w_gnt        = '0;
      w_accept     = 1'b0;
      w_end_burst  = 1'b0;
      w_sel_idx    = r_owner;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               if (!r_hold && w_pick_valid && w_space_ok) begin
                  w_gnt     = w_pick_gnt;
                  w_accept  = 1'b1;
                  w_sel_idx = w_pick_idx;
                  if (req_last[w_pick_idx] || (MAX_BURST == 1)) begin
                     w_end_burst = 1'b1;
                  end else begin
                     w_next_state = ST_BURST;
                  end
               end
            end
            ST_BURST: begin
               if (req[r_owner]) begin
                  if (w_space_ok) begin
                     w_gnt[r_owner] = 1'b1;
                     w_accept       = 1'b1;
                     if (req_last[r_owner] || w_burst_cap) begin
                        w_end_burst  = 1'b1;
                        w_next_state = ST_IDLE;
                     end
                  end
               end else begin
                  // Owner released without a last beat: close with no write.
                  w_end_burst  = 1'b1;
                  w_next_state = ST_IDLE;
               end
            end
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_rr_ptr     <= '0;
         r_owner      <= '0;
         r_beat_cnt   <= '0;
         r_hold       <= 1'b0;
         r_fifo_wr_en <= 1'b0;
         r_fifo_din   <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_busy       <= (w_next_state == ST_BURST);
         r_hold       <= w_end_burst;
         r_fifo_wr_en <= w_accept;
         if (w_accept) begin
            r_fifo_din <= w_sel_data;
            r_owner    <= w_sel_idx;
            r_beat_cnt <= (r_state == ST_IDLE) ? c_beat_w'(1) : w_beat_next[c_beat_w-1:0];
         end
         if (w_end_burst) begin
            r_rr_ptr <= (w_sel_idx == c_idx_w'(NUM_REQ-1)) ? '0 : w_sel_idx + 1'b1;
         end
      end
   end

   assign gnt        = w_gnt;
   assign fifo_wr_en = r_fifo_wr_en;
   assign fifo_din   = r_fifo_din;
   assign busy       = r_busy;
   assign owner      = r_owner;

`ifdef FIFO_WR_ARB_STATS_EN
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
         logic [c_stat_w-1:0] r_cnt;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_cnt <= '0;
            end else if (w_accept && (w_sel_idx == c_idx_w'(gi)) && (r_cnt != {c_stat_w{1'b1}})) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
         assign stat_beats[gi*c_stat_w +: c_stat_w] = r_cnt;
      end
   endgenerate
`endif

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_fifo_wr_arbiter                                          |
// | Purpose  : Directed self-checking bench for fifo_wr_arbiter (default   |
// |            parameters). Covers FIFO_WR_ARB_STATS_EN when defined.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  gnt;
   logic        fifo_wr_en;
   logic [7:0]  fifo_din;
   logic        fifo_full;
   logic [7:0]  fifo_count;
   logic        busy;
   logic [1:0]  owner;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [63:0] stat_beats;
`endif

   int n_checks;
   int n_errors;

   fifo_wr_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .req_last   (req_last),
      .gnt        (gnt),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .fifo_full  (fifo_full),
      .fifo_count (fifo_count),
      .busy       (busy),
      .owner      (owner)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .stat_beats (stat_beats)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input int idx, input logic [7:0] val);
      req_data[idx*8 +: 8] = val;
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst        = 1'b1;
      req        = '0;
      req_data   = '0;
      req_last   = '0;
      fifo_full  = 1'b0;
      fifo_count = '0;

      // Reset state
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
      chk("rst_din", 32'(fifo_din), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);

      // Single beat from requester 0
      rst      = 1'b0;
      req      = 4'b0001;
      req_last = 4'b0001;
      set_data(0, 8'hA5);
      #1;
      chk("single_gnt", 32'(gnt), 32'h1);
      tick();
      chk("single_wr_en", 32'(fifo_wr_en), 32'h1);
      chk("single_din", 32'(fifo_din), 32'hA5);
      chk("single_busy", 32'(busy), 32'h0);
      req = '0;
      #1;
      chk("single_gap_gnt", 32'(gnt), 32'h0);
      tick();
      chk("single_wr_en_off", 32'(fifo_wr_en), 32'h0);
      chk("single_din_hold", 32'(fifo_din), 32'hA5);

      // Round-robin fairness from rr_ptr=0
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      req      = 4'b1111;
      req_last = 4'b1111;
      for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
      #1;
      for (int k = 0; k < 5; k++) begin
         logic [3:0] exp_oh;
         exp_oh = 4'b0001 << (k % 4);
         chk("rr_gnt", 32'(gnt), 32'(exp_oh));
         tick();
         chk("rr_wr_en", 32'(fifo_wr_en), 32'h1);
         chk("rr_din", 32'(fifo_din), 32'(8'h10 + (k % 4)));
         chk("rr_gap_gnt", 32'(gnt), 32'h0);
         tick();
         chk("rr_gap_wr_en", 32'(fifo_wr_en), 32'h0);
      end

      // Burst cap on requester 2; requester 3 waits (rr_ptr=1 now)
      req      = 4'b1100;
      req_last = 4'b1000;
      set_data(3, 8'h33);
      for (int b = 0; b < 8; b++) begin
         set_data(2, 8'(8'h20 + b));
         #1;
         chk("cap_gnt", 32'(gnt), 32'h4);
         tick();
         chk("cap_wr_en", 32'(fifo_wr_en), 32'h1);
         chk("cap_din", 32'(fifo_din), 32'(8'h20 + b));
         chk("cap_busy", 32'(busy), (b < 7) ? 32'h1 : 32'h0);
      end
      chk("cap_gap_gnt", 32'(gnt), 32'h0);
      tick();
      chk("cap_gap_wr_en", 32'(fifo_wr_en), 32'h0);
      chk("cap_next_gnt", 32'(gnt), 32'h8);
      tick();
      chk("cap_next_din", 32'(fifo_din), 32'h33);
      req = '0;
      tick();

      // Full throttle on a burst from requester 0 (rr_ptr=0)
      req      = 4'b0001;
      req_last = 4'b0000;
      set_data(0, 8'h40);
      #1;
      chk("thr_first_gnt", 32'(gnt), 32'h1);
      tick();
      chk("thr_first_wr_en", 32'(fifo_wr_en), 32'h1);
      chk("thr_busy", 32'(busy), 32'h1);
      fifo_count = 8'd63;
      set_data(0, 8'h41);
      #1;
      chk("thr_63_inflight_gnt", 32'(gnt), 32'h0);
      tick();
      chk("thr_stall_wr_en", 32'(fifo_wr_en), 32'h0);
      chk("thr_stall_busy", 32'(busy), 32'h1);
      fifo_full  = 1'b1;
      fifo_count = 8'd0;
      #1;
      chk("thr_full_gnt", 32'(gnt), 32'h0);
      tick();
      fifo_full  = 1'b0;
      fifo_count = 8'd62;
      #1;
      chk("thr_resume_gnt", 32'(gnt), 32'h1);
      tick();
      chk("thr_resume_din", 32'(fifo_din), 32'h41);
      req_last = 4'b0001;
      set_data(0, 8'h42);
      #1;
      chk("thr_last_gnt", 32'(gnt), 32'h1);
      tick();
      chk("thr_last_din", 32'(fifo_din), 32'h42);
      chk("thr_last_busy", 32'(busy), 32'h0);
      req        = '0;
      req_last   = '0;
      fifo_count = '0;
      tick();

      // Owner drop: requester 1 releases after 3 beats (rr_ptr=1)
      req = 4'b0010;
      for (int b = 0; b < 3; b++) begin
         set_data(1, 8'(8'h50 + b));
         #1;
         chk("drop_gnt", 32'(gnt), 32'h2);
         tick();
      end
      chk("drop_busy_before", 32'(busy), 32'h1);
      chk("drop_owner", 32'(owner), 32'h1);
      req = '0;
      #1;
      chk("drop_gnt_off", 32'(gnt), 32'h0);
      tick();
      chk("drop_busy_after", 32'(busy), 32'h0);
      chk("drop_wr_en", 32'(fifo_wr_en), 32'h0);
      req      = 4'b1111;
      req_last = 4'b1111;
      #1;
      chk("drop_gap_gnt", 32'(gnt), 32'h0);
      tick();
      chk("drop_next_gnt", 32'(gnt), 32'h4);
      tick();
      req      = '0;
      req_last = '0;
      tick();

      // Reset in the middle of a burst from requester 2 (rr_ptr=3)
      req = 4'b0100;
      for (int b = 0; b < 3; b++) begin
         set_data(2, 8'(8'h60 + b));
         #1;
         chk("mrst_gnt", 32'(gnt), 32'h4);
         tick();
      end
      rst = 1'b1;
      set_data(2, 8'h63);
      #1;
      chk("mrst_gnt_in_rst", 32'(gnt), 32'h0);
      chk("mrst_inflight_wr_en", 32'(fifo_wr_en), 32'h1);
      chk("mrst_inflight_din", 32'(fifo_din), 32'h62);
      tick();
      chk("mrst_wr_en", 32'(fifo_wr_en), 32'h0);
      chk("mrst_busy", 32'(busy), 32'h0);
      chk("mrst_owner", 32'(owner), 32'h0);
      chk("mrst_din", 32'(fifo_din), 32'h0);
`ifdef FIFO_WR_ARB_STATS_EN
      chk("mrst_stats_lo", stat_beats[31:0], 32'h0);
      chk("mrst_stats_hi", stat_beats[63:32], 32'h0);
`endif
      rst      = 1'b0;
      req      = 4'b1010;
      req_last = 4'b1010;
      set_data(1, 8'h77);
      #1;
      chk("mrst_ptr_gnt", 32'(gnt), 32'h2);
      tick();
      chk("mrst_ptr_owner", 32'(owner), 32'h1);
      chk("mrst_ptr_din", 32'(fifo_din), 32'h77);
`ifdef FIFO_WR_ARB_STATS_EN
      chk("stats_req1", 32'(stat_beats[31:16]), 32'h1);
`endif
      req = '0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
